// File: rtl/hazard_control_unit.sv
// Hazard control unit for a five-stage pipeline.
// Resolves load-use hazards, taken branches and data-memory wait states,
// counts stalled cycles, and latches a fatal error when memory never answers.
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_RD,
    input  logic [4:0]  IF_ID_RS1,
    input  logic [4:0]  IF_ID_RS2,
    input  logic        IF_ID_UsesRS2,
    input  logic        Branch_Taken,
    input  logic        EX_MEM_MemReq,
    input  logic        Mem_Ready,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        Pipe_Hold,
    output logic        Mem_Timeout,
    output logic [15:0] Stall_Count,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10,
        ERROR      = 2'b11
    } state_t;

    // Wait-counter value seen during the last allowed MEM_WAIT cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] stall_q;
    logic        load_use, mem_stall;

    // x0 is never a real dependency; RS2 only matters when the ID instruction reads it.
    assign load_use  = ID_EX_MemRead && (ID_EX_RD != 5'd0) &&
                       ((ID_EX_RD == IF_ID_RS1) ||
                        (IF_ID_UsesRS2 && (ID_EX_RD == IF_ID_RS2)));
    // Mem_Ready only means something while a request is outstanding.
    assign mem_stall = EX_MEM_MemReq && !Mem_Ready;

    // Next-state, wait counter and pipeline control outputs.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Pipe_Hold    = 1'b0;
        Mem_Timeout  = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;

        if (state_q == ERROR) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Hold   = 1'b1;
            Mem_Timeout = 1'b1;
        end else if (mem_stall) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Hold   = 1'b1;
            if (state_q == MEM_WAIT) begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ERROR;
                    wait_d  = 8'd0;
                end else begin
                    wait_d  = wait_q + 8'd1;
                end
            end else begin
                state_d = MEM_WAIT;
                wait_d  = 8'd0;
            end
        end else begin
            // Leaving (or never entering) MEM_WAIT: counter starts fresh next time.
            wait_d = 8'd0;
            if (Branch_Taken) begin
                // ID holds a wrong-path instruction, so any load-use hit is moot.
                IF_ID_Flush  = 1'b1;
                ID_EX_Bubble = 1'b1;
                state_d      = RUN;
            end else if (load_use && (state_q != LOAD_STALL)) begin
                // One bubble is enough for the load to reach MEM; never stall twice.
                PC_Write     = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
                state_d      = LOAD_STALL;
            end else begin
                state_d      = RUN;
            end
        end

        if (rst) begin
            PC_Write     = 1'b1;
            IF_ID_Write  = 1'b1;
            IF_ID_Flush  = 1'b0;
            ID_EX_Bubble = 1'b0;
            Pipe_Hold    = 1'b0;
            Mem_Timeout  = 1'b0;
            state_d      = RUN;
            wait_d       = 8'd0;
        end
    end

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Saturating count of cycles in which the PC was frozen.
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= 16'd0;
        else if (!PC_Write && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign State       = state_q;
    assign Stall_Count = stall_q;

endmodule
